// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: data width, canonical NOP and fetch FSM encoding.
package rv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Request/grant/response handshake between the fetch unit and instruction memory.
interface ifu_fetch_if;
    import rv_pipe_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/ifu_fetch_buf.sv
// Holding register for an instruction captured while fetch is stalled.
module fetch_buf
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RST_VAL = rv_pipe_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_d,
    output logic [XLEN-1:0] o_q
);

    logic [XLEN-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the fetch PC, issues one outstanding imem request
// at a time, buffers under stall and discards stale responses after a redirect.
module ifu_fetch
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    ifu_fetch_if.master     imem,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCplus4F,
    output logic [XLEN-1:0] InstrF,
    output logic            InstrValidF
);

    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_HOLD  = HOLD;
    localparam logic [1:0] S_DROP  = DROP;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_buf_q;

    logic [1:0]      w_nxt_state;
    logic [1:0]      w_issue_state;
    logic [XLEN-1:0] w_nxt_pc;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_addr;
    logic            w_req;
    logic            w_buf_en;
    logic            w_deliver;

    assign w_pc4         = r_pc + 32'd4;
    assign w_target      = PCTargetE & ~32'h0000_0003;
    assign w_issue_state = imem.imem_gnt ? S_WAIT : S_ISSUE;
    assign w_deliver     = !PCSrcE &&
                           ((r_state == S_WAIT && imem.imem_rvalid) || r_state == S_HOLD);

    always_comb begin
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_buf_en    = 1'b0;
        if (PCSrcE) begin
            w_nxt_pc = w_target;
            // A response still in flight must be swallowed before the target can be requested.
            if ((r_state == S_WAIT || r_state == S_DROP) && !imem.imem_rvalid) begin
                w_nxt_state = S_DROP;
            end else begin
                w_req       = 1'b1;
                w_addr      = w_target;
                w_nxt_state = w_issue_state;
            end
        end else begin
            case (r_state)
                S_ISSUE: begin
                    w_req       = 1'b1;
                    w_nxt_state = w_issue_state;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (stallF) begin
                            w_buf_en    = 1'b1;
                            w_nxt_state = S_HOLD;
                        end else begin
                            w_nxt_pc    = w_pc4;
                            w_req       = 1'b1;
                            w_addr      = w_pc4;
                            w_nxt_state = w_issue_state;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stallF) begin
                        w_nxt_pc    = w_pc4;
                        w_req       = 1'b1;
                        w_addr      = w_pc4;
                        w_nxt_state = w_issue_state;
                    end
                end
                S_DROP: begin
                    if (imem.imem_rvalid) begin
                        w_req       = 1'b1;
                        w_nxt_state = w_issue_state;
                    end
                end
                default: w_nxt_state = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_ISSUE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_nxt_state;
            r_pc    <= w_nxt_pc;
        end
    end

    fetch_buf #(
        .RST_VAL (NOP_INSTR)
    ) u_fetch_buf (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_buf_en),
        .i_d   (imem.imem_rdata),
        .o_q   (w_buf_q)
    );

    // Reset masks the outputs in the same cycle, independent of the registered state.
    assign imem.imem_req  = w_req && !reset;
    assign imem.imem_addr = w_addr;

    assign InstrValidF = w_deliver && !reset;
    assign InstrF      = !InstrValidF      ? NOP_INSTR :
                         (r_state == S_HOLD) ? w_buf_q : imem.imem_rdata;
    assign PCF         = reset ? RESET_PC : r_pc;
    assign PCplus4F    = PCF + 32'd4;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: two instances (RESET_PC 0 and 0xFFFF_FFFC) on a
// latency-programmable instruction memory model.
module tb_ifu_fetch;
    import rv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;

    logic [31:0] pcf0, pcp4_0, instr0, pcf1, pcp4_1, instr1;
    logic        valid0, valid1;

    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [1:0]  busy;
    logic [31:0] rd    [2];
    logic [31:0] paddr [2];
    int          cnt   [2];
    int          lat   [2];
    logic [1:0]  req_w;
    logic [31:0] addr_w [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifu_fetch_if bus0 ();
    ifu_fetch_if bus1 ();

    ifu_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .stallF(stallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem(bus0), .PCF(pcf0), .PCplus4F(pcp4_0), .InstrF(instr0), .InstrValidF(valid0)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(reset), .stallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem(bus1), .PCF(pcf1), .PCplus4F(pcp4_1), .InstrF(instr1), .InstrValidF(valid1)
    );

    assign bus0.imem_gnt    = gnt[0];
    assign bus1.imem_gnt    = gnt[1];
    assign bus0.imem_rvalid = rv[0];
    assign bus1.imem_rvalid = rv[1];
    assign bus0.imem_rdata  = rd[0];
    assign bus1.imem_rdata  = rd[1];
    assign req_w[0]  = bus0.imem_req;
    assign req_w[1]  = bus1.imem_req;
    assign addr_w[0] = bus0.imem_addr;
    assign addr_w[1] = bus1.imem_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory: response arrives lat cycles after the accepting cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                busy[i] <= 1'b0;
                rv[i]   <= 1'b0;
            end else begin
                rv[i] <= 1'b0;
                if (busy[i]) begin
                    if (cnt[i] == 1) begin
                        rv[i]   <= 1'b1;
                        rd[i]   <= memf(paddr[i]);
                        busy[i] <= 1'b0;
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                end
                if (req_w[i] && gnt[i]) begin
                    if (lat[i] == 1) begin
                        rv[i] <= 1'b1;
                        rd[i] <= memf(addr_w[i]);
                    end else begin
                        busy[i]  <= 1'b1;
                        cnt[i]   <= lat[i] - 1;
                        paddr[i] <= addr_w[i];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        gnt = 2'b01; lat[0] = 1; lat[1] = 1;
        rd[0] = 32'h0; rd[1] = 32'h0; cnt[0] = 0; cnt[1] = 0;
        paddr[0] = 32'h0; paddr[1] = 32'h0;
        repeat (3) nxt();
        #1;
        chk("rst_req0",   {31'h0, bus0.imem_req}, 32'h0);
        chk("rst_vld0",   {31'h0, valid0}, 32'h0);
        chk("rst_instr0", instr0, 32'h0000_0013);
        chk("rst_pcf0",   pcf0, 32'h0);
        chk("rst_pcp4_0", pcp4_0, 32'h4);
        chk("rst_pcf1",   pcf1, 32'hFFFF_FFFC);
        chk("rst_pcp4_1", pcp4_1, 32'h0);
        chk("rst_req1",   {31'h0, bus1.imem_req}, 32'h0);

        nxt(); reset = 1'b0; #1;
        chk("first_req0",  {31'h0, bus0.imem_req}, 32'h1);
        chk("first_addr0", bus0.imem_addr, 32'h0);
        chk("first_vld0",  {31'h0, valid0}, 32'h0);
        chk("bp_req1_a",   {31'h0, bus1.imem_req}, 32'h1);
        chk("bp_addr1_a",  bus1.imem_addr, 32'hFFFF_FFFC);

        nxt(); #1;
        chk("s0_vld",   {31'h0, valid0}, 32'h1);
        chk("s0_pcf",   pcf0, 32'h0);
        chk("s0_instr", instr0, 32'hDEAD_0000);
        chk("s0_req",   {31'h0, bus0.imem_req}, 32'h1);
        chk("s0_addr",  bus0.imem_addr, 32'h4);
        chk("bp_req1_b",  {31'h0, bus1.imem_req}, 32'h1);
        chk("bp_addr1_b", bus1.imem_addr, 32'hFFFF_FFFC);

        nxt(); gnt[1] = 1'b1; #1;
        chk("s1_pcf",   pcf0, 32'h4);
        chk("s1_instr", instr0, 32'hDEAD_0004);
        chk("w1_vld_a", {31'h0, valid1}, 32'h0);

        for (int k = 0; k < 3; k++) begin
            nxt(); stallF = 1'b1; #1;
            chk("st_vld",   {31'h0, valid0}, 32'h1);
            chk("st_pcf",   pcf0, 32'h8);
            chk("st_instr", instr0, 32'hDEAD_0008);
            chk("st_req",   {31'h0, bus0.imem_req}, 32'h0);
            if (k == 0) begin
                chk("w1_pcf_a",   pcf1, 32'hFFFF_FFFC);
                chk("w1_instr_a", instr1, 32'h2152_FFFC);
            end
            if (k == 1) begin
                chk("w1_vld_b",   {31'h0, valid1}, 32'h1);
                chk("w1_pcf_b",   pcf1, 32'h0);
                chk("w1_instr_b", instr1, 32'hDEAD_0000);
            end
        end

        nxt(); stallF = 1'b0; #1;
        chk("unst_pcf",  pcf0, 32'h8);
        chk("unst_req",  {31'h0, bus0.imem_req}, 32'h1);
        chk("unst_addr", bus0.imem_addr, 32'hC);

        nxt(); #1;
        chk("post_pcf",   pcf0, 32'hC);
        chk("post_instr", instr0, 32'hDEAD_000C);
        for (int k = 0; k < 4; k++) begin
            nxt(); #1;
            chk("stream_pcf", pcf0, 32'h10 + 32'(4 * k));
            chk("stream_vld", {31'h0, valid0}, 32'h1);
        end

        nxt(); PCSrcE = 1'b1; PCTargetE = 32'h0000_0103; #1;
        chk("rd_vld",   {31'h0, valid0}, 32'h0);
        chk("rd_instr", instr0, 32'h0000_0013);
        chk("rd_req",   {31'h0, bus0.imem_req}, 32'h1);
        chk("rd_addr",  bus0.imem_addr, 32'h100);

        nxt(); PCSrcE = 1'b0; lat[0] = 3; #1;
        chk("rd_tgt_vld",   {31'h0, valid0}, 32'h1);
        chk("rd_tgt_pcf",   pcf0, 32'h100);
        chk("rd_tgt_instr", instr0, 32'hDEAD_0100);

        for (int k = 0; k < 2; k++) begin
            nxt(); #1;
            chk("lat_vld", {31'h0, valid0}, 32'h0);
            chk("lat_req", {31'h0, bus0.imem_req}, 32'h0);
        end

        nxt(); PCSrcE = 1'b1; PCTargetE = 32'h40; #1;
        chk("r40_vld",  {31'h0, valid0}, 32'h0);
        chk("r40_addr", bus0.imem_addr, 32'h40);

        nxt(); PCTargetE = 32'h200; #1;
        chk("drop_req", {31'h0, bus0.imem_req}, 32'h0);
        chk("drop_vld", {31'h0, valid0}, 32'h0);

        nxt(); PCSrcE = 1'b0; #1;
        chk("drop_state", {30'h0, dut0.r_state}, 32'h3);
        chk("drop_req2",  {31'h0, bus0.imem_req}, 32'h0);

        nxt(); #1;
        chk("stale_vld",   {31'h0, valid0}, 32'h0);
        chk("stale_instr", instr0, 32'h0000_0013);
        chk("stale_req",   {31'h0, bus0.imem_req}, 32'h1);
        chk("stale_addr",  bus0.imem_addr, 32'h200);

        for (int k = 0; k < 2; k++) begin
            nxt(); #1;
            chk("w200_vld", {31'h0, valid0}, 32'h0);
        end

        nxt(); stallF = 1'b1; lat[0] = 1; #1;
        chk("t200_vld",   {31'h0, valid0}, 32'h1);
        chk("t200_pcf",   pcf0, 32'h200);
        chk("t200_instr", instr0, 32'hDEAD_0200);

        nxt(); reset = 1'b1; #1;
        chk("mrst_req", {31'h0, bus0.imem_req}, 32'h0);
        chk("mrst_vld", {31'h0, valid0}, 32'h0);
        chk("mrst_pcf", pcf0, 32'h0);

        nxt(); reset = 1'b0; stallF = 1'b0; #1;
        chk("rel_req",  {31'h0, bus0.imem_req}, 32'h1);
        chk("rel_addr", bus0.imem_addr, 32'h0);
        chk("rel_vld",  {31'h0, valid0}, 32'h0);

        nxt(); #1;
        chk("rel_pcf",   pcf0, 32'h0);
        chk("rel_instr", instr0, 32'hDEAD_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
